// File: rtl/cpu_presser_if.sv
// Button-level bus between the synthetic player and whatever consumes its presses.
// The consumer side owns enable/difficulty; the presser drives the rest.
interface cpu_presser_if;
    logic       enable;
    logic [9:0] difficulty;
    logic       pressed;
    logic       busy;
    logic [9:0] rand_val;
    logic [7:0] press_count;

    modport master (
        output enable, difficulty,
        input  pressed, busy, rand_val, press_count
    );

    modport slave (
        input  enable, difficulty,
        output pressed, busy, rand_val, press_count
    );
endinterface

// File: rtl/cpu_presser.sv
// Computer opponent for tug-of-war: LFSR-gated presses with fixed hold and guaranteed gap.
// Optional press counter enabled by defining CPU_PRESS_COUNT_EN.
module cpu_presser #(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    cpu_presser_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_nextState;
    logic [7:0] r_holdCnt;
    logic [7:0] r_gapCnt;
    logic [9:0] r_lfsr;
    logic       r_pressed;
    logic       w_busy;
    logic       w_startPress;
    logic       w_lfsrFb;

    // XNOR feedback keeps all-ones as the lock-up state, so a zero reset value is safe.
    assign w_lfsrFb = ~(r_lfsr[9] ^ r_lfsr[6]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState  = r_state;
        w_startPress = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.enable && (r_lfsr < bus.difficulty)) begin
                    w_nextState  = HOLD;
                    w_startPress = 1'b1;
                end
            end
            HOLD: begin
                if (r_holdCnt == 8'd0) begin
                    w_nextState = GAP;
                end
            end
            GAP: begin
                if (r_gapCnt == 8'd0) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    always_comb begin
        w_busy = (r_state == HOLD) || (r_state == GAP);
    end

    // Counters are loaded with N-1 so each phase lasts exactly N cycles.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lfsr    <= 10'h000;
            r_pressed <= 1'b0;
            r_holdCnt <= 8'd0;
            r_gapCnt  <= 8'd0;
        end else begin
            r_lfsr    <= {r_lfsr[8:0], w_lfsrFb};
            r_pressed <= (w_nextState == HOLD);

            if (w_startPress) begin
                r_holdCnt <= 8'(HOLD_CYCLES - 1);
            end else if ((r_state == HOLD) && (r_holdCnt != 8'd0)) begin
                r_holdCnt <= r_holdCnt - 8'd1;
            end

            if ((r_state == HOLD) && (w_nextState == GAP)) begin
                r_gapCnt <= 8'(GAP_CYCLES - 1);
            end else if ((r_state == GAP) && (r_gapCnt != 8'd0)) begin
                r_gapCnt <= r_gapCnt - 8'd1;
            end
        end
    end

`ifdef CPU_PRESS_COUNT_EN
    logic [7:0] r_pressCount;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pressCount <= 8'h00;
        end else if (w_startPress && (r_pressCount != 8'hFF)) begin
            r_pressCount <= r_pressCount + 8'h01;
        end
    end

    assign bus.press_count = r_pressCount;
`else
    assign bus.press_count = 8'h00;
`endif

    assign bus.pressed  = r_pressed;
    assign bus.busy     = w_busy;
    assign bus.rand_val = r_lfsr;

endmodule

// File: tb/tb_cpu_presser.sv
// Directed bench for cpu_presser: LFSR sequence, press timing, enable/reset interaction, counter.
// A second instance with 1-cycle hold/gap exercises press-counter saturation.
module tb_cpu_presser;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;

    int totalChecks = 0;
    int badChecks   = 0;

    cpu_presser_if busA ();
    cpu_presser_if busB ();

    cpu_presser #(.HOLD_CYCLES(4), .GAP_CYCLES(4)) u_dutA (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (busA.slave)
    );

    cpu_presser #(.HOLD_CYCLES(1), .GAP_CYCLES(1)) u_dutB (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (busB.slave)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        totalChecks++;
        if (observed !== expected) begin
            badChecks++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic en, input logic [9:0] diff);
        rst              = r;
        busA.enable      = en;
        busA.difficulty  = diff;
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, 10'h000);
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [7:0] countExp(input int n);
`ifdef CPU_PRESS_COUNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return (n >= 0) ? 8'h00 : 8'h00;
`endif
    endfunction

    logic [9:0] lfsrExp [9] = '{10'h000, 10'h001, 10'h003, 10'h007, 10'h00F,
                                10'h01F, 10'h03F, 10'h07F, 10'h0FE};

    initial begin
        int rises;
        int stalls;
        logic prevPressed;
        logic [9:0] prevRand;

        busB.enable     = 1'b1;
        busB.difficulty = 10'h3FF;
        applyStimulus(1'b1, 1'b0, 10'h000);

        // LFSR sequence from reset, enable low
        resetDut();
        checkOutput("rstPressed", 32'(busA.pressed), 32'd0);
        checkOutput("rstBusy", 32'(busA.busy), 32'd0);
        checkOutput("rstRand", 32'(busA.rand_val), 32'h000);
        checkOutput("rstCount", 32'(busA.press_count), 32'h00);
        applyStimulus(1'b0, 1'b0, 10'h000);
        for (int i = 0; i < 9; i++) begin
            checkOutput($sformatf("lfsr%0d", i), 32'(busA.rand_val), 32'(lfsrExp[i]));
            checkOutput($sformatf("idlePressed%0d", i), 32'(busA.pressed), 32'd0);
            checkOutput($sformatf("idleBusy%0d", i), 32'(busA.busy), 32'd0);
            @(negedge clk);
        end

        // Max difficulty: 4 high, 5 low, period 9
        resetDut();
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        rises = 0;
        prevPressed = busA.pressed;
        for (int k = 1; k <= 90; k++) begin
            @(negedge clk);
            checkOutput($sformatf("maxPressed%0d", k), 32'(busA.pressed), 32'(((k - 1) % 9) < 4));
            checkOutput($sformatf("maxBusy%0d", k), 32'(busA.busy), 32'(((k - 1) % 9) < 8));
            if (busA.pressed && !prevPressed) rises++;
            prevPressed = busA.pressed;
        end
        checkOutput("maxRises", 32'(rises), 32'd10);
        checkOutput("maxCount", 32'(busA.press_count), 32'(countExp(10)));

        // Zero difficulty never presses; LFSR keeps moving
        resetDut();
        applyStimulus(1'b0, 1'b1, 10'h000);
        rises = 0;
        stalls = 0;
        prevPressed = busA.pressed;
        prevRand = busA.rand_val;
        for (int k = 1; k <= 2000; k++) begin
            @(negedge clk);
            if (busA.pressed && !prevPressed) rises++;
            if (busA.rand_val == prevRand) stalls++;
            prevPressed = busA.pressed;
            prevRand = busA.rand_val;
        end
        checkOutput("zeroRises", 32'(rises), 32'd0);
        checkOutput("zeroStalls", 32'(stalls), 32'd0);
        checkOutput("zeroCount", 32'(busA.press_count), 32'h00);

        // Enable dropped in the second HOLD cycle
        resetDut();
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if (k == 2) applyStimulus(1'b0, 1'b0, 10'h3FF);
            checkOutput($sformatf("dropPressed%0d", k), 32'(busA.pressed), 32'(k <= 4));
            checkOutput($sformatf("dropBusy%0d", k), 32'(busA.busy), 32'(k <= 8));
        end

        // Reset in the third HOLD cycle
        resetDut();
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        repeat (3) @(negedge clk);
        checkOutput("midHoldPressed", 32'(busA.pressed), 32'd1);
        applyStimulus(1'b1, 1'b1, 10'h3FF);
        @(negedge clk);
        checkOutput("midRstPressed", 32'(busA.pressed), 32'd0);
        checkOutput("midRstBusy", 32'(busA.busy), 32'd0);
        checkOutput("midRstRand", 32'(busA.rand_val), 32'h000);
        checkOutput("midRstCount", 32'(busA.press_count), 32'h00);
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        @(negedge clk);
        checkOutput("restartRand", 32'(busA.rand_val), 32'h001);
        checkOutput("restartPressed", 32'(busA.pressed), 32'd1);

        // Counter saturation on the 1/1 instance, press period 3
        rst2 = 1'b0;
        repeat (762) @(negedge clk);
        checkOutput("satCount254", 32'(busB.press_count), 32'(countExp(254)));
        repeat (38) @(negedge clk);
        checkOutput("satCountFF", 32'(busB.press_count), 32'(countExp(267)));
        repeat (30) @(negedge clk);
        checkOutput("satHold", 32'(busB.press_count), 32'(countExp(277)));

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule

// File: doc/cpu_presser.md
Name: cpu_presser

Overview:
- Synthetic "player" that drives a button-level signal into the tug-of-war input path.
- Produces well-formed presses: a clean rising edge, a fixed high time, then a guaranteed low gap. A downstream rising-edge detector therefore sees exactly one pulse per press.
- Press decisions come from a 10-bit XNOR LFSR compared against a difficulty threshold. It replaces a human switch for the computer opponent.

Parameters:
- HOLD_CYCLES, 4, number of cycles `pressed` stays high per press (legal range 1..255).
- GAP_CYCLES, 4, minimum cycles in the GAP state after release (legal range 1..255).

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- enable  input  1  allows new presses to start; sampled only in IDLE.
- difficulty  input  10  press threshold; a press starts when rand_val < difficulty.
- pressed  output  1  registered button level for the downstream edge detector.
- busy  output  1  high while in the HOLD or GAP state.
- rand_val  output  10  current LFSR value, for observation and debug.
- press_count  output  8  number of presses started (see Optional Feature).

Behaviour:
- Reset (synchronous; takes effect on the next rising edge, including mid-press):
  - state=IDLE, pressed=0, busy=0, rand_val=10'h000, press_count=0, hold/gap counters=0.
  - A HOLD or GAP in progress is abandoned immediately.
- LFSR:
  - Advances every non-reset cycle, in all states.
  - Update: rand_val <= {rand_val[8:0], fb}, where fb = ~(rand_val[9] ^ rand_val[6]).
  - The all-ones lock-up value is unreachable from reset.
- State IDLE:
  - If enable=1 and rand_val < difficulty (unsigned, using the pre-shift value): go to HOLD, set pressed<=1, load the hold counter.
  - Otherwise stay in IDLE with pressed=0.
- State HOLD:
  - pressed=1 for exactly HOLD_CYCLES cycles.
  - On the last cycle: go to GAP, set pressed<=0, load the gap counter.
- State GAP:
  - pressed=0 for GAP_CYCLES cycles, then go to IDLE.
- Timing consequences:
  - Minimum low time between presses is GAP_CYCLES+1 cycles (includes the IDLE evaluation cycle).
  - Minimum press period is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- Outputs and latency:
  - pressed rises one cycle after the qualifying IDLE sample.
  - busy = (state==HOLD) || (state==GAP), decoded from registered state.
- enable behaviour:
  - Deasserting enable during HOLD or GAP does not truncate the press; the block finishes the sequence, then idles.
  - Asserting enable during HOLD or GAP has no effect until IDLE.
- difficulty behaviour:
  - difficulty=0: never presses.
  - difficulty=10'h3FF: presses at every IDLE visit while enabled, because rand_val never equals 10'h3FF.
  - difficulty may change any cycle; only the value sampled in IDLE matters.
- Only the pressed/state/counter registers and the LFSR hold state. There are no combinational paths from inputs to pressed.

Optional Feature:
- Macro: CPU_PRESS_COUNT_EN.
- Defined:
  - press_count is an 8-bit counter that increments on each IDLE->HOLD transition.
  - It saturates at 8'hFF; no wrap.
  - It is cleared only by Reset.
- Undefined:
  - The counter logic is omitted and press_count is tied to 8'h00.
  - The port list is unchanged.

Test Plan:
- LFSR sequence: Reset for 2 cycles, enable=0 -> rand_val over successive cycles = 000, 001, 003, 007, 00F, 01F, 03F, 07F, 0FE; pressed stays 0 and busy stays 0 throughout.
- Max difficulty: difficulty=10'h3FF, enable=1 from reset release, defaults -> pressed high 4 cycles, low 5 cycles, period 9; exactly 10 rising edges in 90 cycles.
- Zero difficulty: difficulty=0, enable=1 for 2000 cycles -> pressed never rises; rand_val keeps advancing; press_count=0.
- Enable drop mid-HOLD: start a press at difficulty=3FF, drop enable in the 2nd HOLD cycle -> pressed still high 4 cycles total, GAP runs 4 cycles, then the block idles with no further presses.
- Reset mid-press: assert Reset in the 3rd HOLD cycle -> next edge pressed=0, busy=0, rand_val=000, press_count=0; after release the sequence restarts from 001.
- Saturation (CPU_PRESS_COUNT_EN defined, HOLD_CYCLES=1, GAP_CYCLES=1, difficulty=3FF) -> press_count reaches FF after 255 presses and holds FF; with the macro undefined, press_count=00 throughout.
